// File: rtl/fetch_pkg.sv
// Shared widths, default halt opcode and FSM state encoding for the fetch stage.
package fetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;

  localparam logic [INSTR_W-1:0] HALT_OPCODE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: wrapping increment, range-checked redirect load.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int                MEM_DEPTH = 6,
  parameter logic [ADDR_W-1:0] PC_RESET  = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              increment,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic              bad_target
);

  // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(MEM_DEPTH - 1);

  logic in_range;

  assign in_range   = ({1'b0, target} < DEPTH_X);
  assign bad_target = load && !in_range;

  // Load wins over increment; an out-of-range load parks the PC at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_RESET;
    end else if (load) begin
      pc <= in_range ? target : '0;
    end else if (increment) begin
      pc <= (pc == LAST) ? '0 : pc + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, captures memory words into the IR and hands them
// to decode over valid/ready. Handles redirects, halt opcode and range faults.
//
// state | meaning
// IDLE  | out of reset, waiting for enable
// RUN   | fetching while enable is high
// HALT  | halt word captured, waiting for a branch to resume
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                 MEM_DEPTH   = 6,
  parameter logic [ADDR_W-1:0]  PC_RESET    = 8'h00,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic [ADDR_W-1:0]  instruction_address,
  input  logic [INSTR_W-1:0] instruction_data,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] ir_data,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic               halted,
  output logic               fault
);

  fetch_state_t state, state_next;

  logic              cap;
  logic              branch_act;
  logic              bad_target;
  logic [ADDR_W-1:0] pc;

  assign branch_act = branch_valid && (state != IDLE);
  assign cap        = (state == RUN) && enable && !branch_valid && (!ir_valid || ir_ready);

  assign instruction_address = pc;

  pc_reg #(
    .MEM_DEPTH (MEM_DEPTH),
    .PC_RESET  (PC_RESET)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (branch_act),
    .increment  (cap),
    .target     (branch_target),
    .pc         (pc),
    .bad_target (bad_target)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: halt on capturing the halt word, only a branch leaves HALT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable) state_next = RUN;
      RUN:  if (cap && (instruction_data == HALT_OPCODE)) state_next = HALT;
      HALT: if (branch_valid) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    halted = (state == HALT);
  end

  // Instruction register: a redirect flushes, capture refills, transfer drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_data  <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (branch_act) begin
      ir_valid <= 1'b0;
    end else if (cap) begin
      ir_data  <= instruction_data;
      ir_pc    <= pc;
      ir_valid <= 1'b1;
    end else if (ir_valid && ir_ready) begin
      ir_valid <= 1'b0;
    end
  end

  // Sticky fault on any out-of-range redirect; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (bad_target) begin
      fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch with a behavioural instruction memory.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] instruction_address;
  logic [7:0] instruction_data;
  logic       branch_valid;
  logic [7:0] branch_target;
  logic [7:0] ir_data;
  logic [7:0] ir_pc;
  logic       ir_valid;
  logic       ir_ready;
  logic       halted;
  logic       fault;

  logic [7:0]  mem [0:7];
  logic [15:0] exp_q [$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign instruction_data = (instruction_address < 8'd6) ? mem[instruction_address[2:0]] : 8'h00;

  instruction_fetch #(
    .MEM_DEPTH   (6),
    .PC_RESET    (8'h00),
    .HALT_OPCODE (8'hFF)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enable              (enable),
    .instruction_address (instruction_address),
    .instruction_data    (instruction_data),
    .branch_valid        (branch_valid),
    .branch_target       (branch_target),
    .ir_data             (ir_data),
    .ir_pc               (ir_pc),
    .ir_valid            (ir_valid),
    .ir_ready            (ir_ready),
    .halted              (halted),
    .fault               (fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [7:0] a);
    exp_q.push_back({d, a});
  endtask

  // Monitor: every accepted (non-flushed) IR transfer is checked against the queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ir_valid === 1'b1 && ir_ready === 1'b1 && branch_valid === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_transfer", {16'h0, ir_data, ir_pc}, 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("sb_ir_data", {24'h0, ir_data}, {24'h0, e[15:8]});
        check("sb_ir_pc",   {24'h0, ir_pc},   {24'h0, e[7:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'd10 + 8'(i);
    rst_n = 1'b1; enable = 1'b0; branch_valid = 1'b0; branch_target = 8'h00; ir_ready = 1'b0;

    // Reset asserted mid-cycle takes effect immediately.
    #12;
    rst_n = 1'b0;
    #1;
    check("rst_addr",     {24'h0, instruction_address}, 32'h0);
    check("rst_ir_valid", {31'h0, ir_valid}, 32'h0);
    check("rst_ir_data",  {24'h0, ir_data}, 32'h0);
    check("rst_ir_pc",    {24'h0, ir_pc}, 32'h0);
    check("rst_halted",   {31'h0, halted}, 32'h0);
    check("rst_fault",    {31'h0, fault}, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_addr",  {24'h0, instruction_address}, 32'h0);
      check("idle_valid", {31'h0, ir_valid}, 32'h0);
    end

    // Straight-line fetch with wrap: 10..15 then 10, 11.
    for (int i = 0; i < 6; i++) push(8'd10 + 8'(i), 8'(i));
    push(8'd10, 8'd0);
    push(8'd11, 8'd1);
    enable = 1'b1; ir_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 1) check("lat_valid_edge1", {31'h0, ir_valid}, 32'h0);
      if (i == 2) begin
        check("lat_valid_edge2", {31'h0, ir_valid}, 32'h1);
        check("lat_data_edge2",  {24'h0, ir_data}, 32'd10);
      end
    end
    enable = 1'b0;
    tick();
    check("wrap_valid_drained", {31'h0, ir_valid}, 32'h0);
    check("wrap_pc", {24'h0, instruction_address}, 32'd2);
    check("wrap_sb_empty", exp_q.size(), 32'd0);

    // Backpressure on the word from address 2.
    push(8'd12, 8'd2);
    push(8'd13, 8'd3);
    enable = 1'b1; ir_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_data",  {24'h0, ir_data}, 32'd12);
      check("bp_pc",    {24'h0, ir_pc}, 32'd2);
      check("bp_addr",  {24'h0, instruction_address}, 32'd3);
      check("bp_valid", {31'h0, ir_valid}, 32'h1);
    end
    ir_ready = 1'b1;
    tick();
    check("bp_next_data", {24'h0, ir_data}, 32'd13);
    enable = 1'b0;
    tick();
    check("bp_sb_empty", exp_q.size(), 32'd0);

    // Branch flush: the word at 4 is captured, then flushed by a branch to 4.
    enable = 1'b1; ir_ready = 1'b1;
    tick();
    check("br_pre_valid", {31'h0, ir_valid}, 32'h1);
    branch_valid = 1'b1; branch_target = 8'd4;
    tick();
    check("br_flush_valid", {31'h0, ir_valid}, 32'h0);
    check("br_pc", {24'h0, instruction_address}, 32'd4);
    branch_valid = 1'b0;
    push(8'd14, 8'd4);
    tick();
    check("br_post_valid", {31'h0, ir_valid}, 32'h1);
    check("br_post_data",  {24'h0, ir_data}, 32'd14);
    check("br_post_pc",    {24'h0, ir_pc}, 32'd4);
    enable = 1'b0;
    tick();
    check("br_sb_empty", exp_q.size(), 32'd0);

    // Halt word at address 3.
    mem[3] = 8'hFF;
    branch_valid = 1'b1; branch_target = 8'd0;
    tick();
    branch_valid = 1'b0;
    push(8'd10, 8'd0); push(8'd11, 8'd1); push(8'd12, 8'd2); push(8'hFF, 8'd3);
    enable = 1'b1; ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("halt_halted", {31'h0, halted}, 32'h1);
    check("halt_data",   {24'h0, ir_data}, 32'hFF);
    check("halt_ir_pc",  {24'h0, ir_pc}, 32'd3);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_no_valid", {31'h0, ir_valid}, 32'h0);
      check("halt_stays",    {31'h0, halted}, 32'h1);
      check("halt_pc_hold",  {24'h0, instruction_address}, 32'd4);
    end
    branch_valid = 1'b1; branch_target = 8'd0;
    tick();
    check("resume_halted", {31'h0, halted}, 32'h0);
    check("resume_pc", {24'h0, instruction_address}, 32'd0);
    branch_valid = 1'b0;
    push(8'd10, 8'd0);
    tick();
    check("resume_data", {24'h0, ir_data}, 32'd10);
    enable = 1'b0;
    tick();
    check("halt_sb_empty", exp_q.size(), 32'd0);
    mem[3] = 8'd13;

    // Out-of-range branch target sets the sticky fault.
    branch_valid = 1'b1; branch_target = 8'h09;
    tick();
    check("fault_pc",  {24'h0, instruction_address}, 32'd0);
    check("fault_set", {31'h0, fault}, 32'h1);
    branch_target = 8'd1;
    tick();
    branch_valid = 1'b0;
    check("fault_legal_pc", {24'h0, instruction_address}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fault_sticky", {31'h0, fault}, 32'h1);
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("fault_rst_clear", {31'h0, fault}, 32'h0);
    check("fault_rst_addr",  {24'h0, instruction_address}, 32'h0);
    check("fault_rst_valid", {31'h0, ir_valid}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("final_sb_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage sitting directly upstream of `instruction_mem`. It owns the program counter, drives `instruction_address` into the memory and captures the returned `instruction_data` into an instruction register. The register is handed to decode over a valid/ready handshake. The block also handles branch redirects, flush, halt-on-opcode and out-of-range address faults.

## Interface
Parameters:
- `MEM_DEPTH`, 6: number of valid instruction words; legal addresses are 0..MEM_DEPTH-1.
- `PC_RESET`, 8'h00: PC value after reset.
- `HALT_OPCODE`, 8'hFF: instruction word that halts fetch.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  level; fetch is permitted while high.
- `instruction_address`  out  8  to `instruction_mem`; always equals the PC register.
- `instruction_data`  in  8  from `instruction_mem`; combinational read of `instruction_address`.
- `branch_valid`  in  1  single-cycle redirect request.
- `branch_target`  in  8  redirect address, sampled when `branch_valid`=1.
- `ir_data`  out  8  captured instruction.
- `ir_pc`  out  8  address the captured instruction came from.
- `ir_valid`  out  1  IR holds an instruction for decode.
- `ir_ready`  in  1  decode accepts the IR this cycle.
- `halted`  out  1  high in the HALT state.
- `fault`  out  1  sticky; set by an out-of-range branch target.

## Operation
- States:
  - IDLE: after reset.
  - RUN.
  - HALT.
- State transitions:
  - IDLE→RUN when `enable`=1.
  - RUN→HALT when a word equal to `HALT_OPCODE` is captured.
  - HALT→RUN on `branch_valid`=1.
  - No other exits from HALT; `enable` has no effect in HALT.
- Capture condition (`cap`): state=RUN, `enable`=1, `branch_valid`=0, and (`ir_valid`=0 or `ir_ready`=1).
- On `cap`:
  - `ir_data`←`instruction_data`, `ir_pc`←PC, `ir_valid`←1.
  - PC←PC+1, wrapping to 0 when PC=MEM_DEPTH-1.
- Handshake:
  - A transfer occurs on any edge with `ir_valid`=1 and `ir_ready`=1.
  - If that edge is not also `cap`, `ir_valid`←0.
  - While `ir_valid`=1 and `ir_ready`=0, IR and PC hold stable.
- Branch (`branch_valid`=1, any state except IDLE):
  - Branch has priority over capture; IR is flushed (`ir_valid`←0).
  - PC←`branch_target` if target < MEM_DEPTH.
  - Otherwise PC←0 and `fault`←1.
  - Branch in IDLE is ignored.
- Halt:
  - The halt word is delivered to decode like any other instruction.
  - PC holds at halt address+1 (with wrap).
  - No further captures occur.
- `enable`=0 in RUN: no capture and PC holds. A pending IR can still be consumed.
- `fault` clears only on reset.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - State=IDLE, PC=`PC_RESET`, `instruction_address`=`PC_RESET`.
  - `ir_data`=0, `ir_pc`=0, `ir_valid`=0, `halted`=0, `fault`=0.
- Reset mid-run: all state clears immediately; any in-flight IR is discarded.
- Latency:
  - Instruction at address A appears on `ir_data` at the edge after the cycle where PC=A and `cap`.
  - First `ir_valid` comes 2 edges after `enable` rises from IDLE.
- Throughput: 1 instruction/cycle with `ir_ready` held high.
- Branch: first post-branch instruction is valid 2 edges after the `branch_valid` cycle (1-cycle bubble).
- `halted` rises on the same edge that captures the halt word.
- `instruction_address` changes only on clock edges or reset.

## Structure
- Shared package `fetch_pkg` holds:
  - `ADDR_W`=8, `INSTR_W`=8, default `HALT_OPCODE`.
  - The state enum `fetch_state_t` {IDLE, RUN, HALT}.
- One sub-module, `pc_reg`:
  - Inputs: load, increment, target.
  - Performs the wrap and range check and flags an out-of-range load.
  - Everything else is the top-level FSM plus the IR register.

## Test plan
- Reset and idle: assert `rst_n`=0 mid-cycle → all outputs at reset values immediately. Release reset with `enable`=0 → `instruction_address`=0 and `ir_valid`=0 indefinitely.
- Straight-line fetch and wrap: memory = 10,11,12,13,14,15; `enable`=1, `ir_ready`=1 → `ir_data` sequence 10..15 then 10, with `ir_pc` 0..5 then 0.
- Backpressure: `ir_ready`=0 for 3 cycles while holding the word from address 2 → `ir_data`=12, `ir_pc`=2 and PC=3 all stable. Release → next word is 13.
- Branch flush: `branch_valid`=1, target 4, while `ir_valid`=1 and `ir_ready`=1 → `ir_valid`=0 next edge, then `ir_data`=14 with `ir_pc`=4.
- Halt: word FF at address 3 → FF is delivered with `ir_pc`=3, `halted`=1, and no further `ir_valid`. Branch to 0 → `halted`=0 and fetch resumes from 10.
- Fault: branch target 8'h09 with MEM_DEPTH=6 → PC=0, `fault`=1, and `fault` stays high until `rst_n`=0.
